// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_gen_pkg
// Description : State encoding and length-clamp helper for sequence_generator.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    FINISH = 2'b11
  } seq_state_t;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_gen_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_gen_down_counter
// Description : Loadable, enable-gated down counter that saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_gen_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load wins over decrement; decrement never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : sequence_generator
// Description : MSB-first bit-serial pattern transmitter with repeat count and
//               valid/ready backpressure. Define SEQ_GEN_PARITY_EN to append an
//               even-parity beat after every repetition.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int REP_W = 4,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_repeat,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len_eff;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_accept;

  logic             w_idx_load;
  logic [LEN_W-1:0] w_idx_val;
  logic             w_idx_en;
  logic [LEN_W-1:0] w_idx;
  logic             w_idx_zero;

  logic             w_rep_load;
  logic             w_rep_en;
  logic [REP_W-1:0] w_rep;
  logic             w_rep_zero;

  logic [PAT_W-1:0] w_shifted;
  logic             w_data_bit;

  assign w_len_eff  = LEN_W'(clamp_len(int'(load_len), PAT_W));
  assign w_accept   = load_valid && load_ready;
  assign w_shifted  = r_pattern >> w_idx;
  assign w_data_bit = w_shifted[0];

  seq_gen_down_counter #(.W(LEN_W)) u_idx_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_idx_load),
    .i_load_val(w_idx_val),
    .i_en      (w_idx_en),
    .o_count   (w_idx),
    .o_zero    (w_idx_zero)
  );

  seq_gen_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_rep_load),
    .i_load_val(load_repeat),
    .i_en      (w_rep_en),
    .o_count   (w_rep),
    .o_zero    (w_rep_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pattern <= '0;
      r_len_eff <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pattern <= load_pattern;
        r_len_eff <= w_len_eff;
      end
    end
  end

`ifdef SEQ_GEN_PARITY_EN
  logic r_parity;

  // Running XOR of the data bits of the current repetition.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_parity <= 1'b0;
    end else if ((r_state == SHIFT) && out_ready) begin
      r_parity <= r_parity ^ w_data_bit;
    end else if ((r_state == PARITY) && out_ready) begin
      r_parity <= 1'b0;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_load  = 1'b0;
    w_idx_val   = r_len_eff - LEN_W'(1);
    w_idx_en    = 1'b0;
    w_rep_load  = 1'b0;
    w_rep_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_idx_load  = 1'b1;
          w_rep_load  = 1'b1;
          w_idx_val   = (w_len_eff == '0) ? '0 : (w_len_eff - LEN_W'(1));
          w_state_nxt = (w_len_eff == '0) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (!w_idx_zero) begin
            w_idx_en = 1'b1;
          end else begin
`ifdef SEQ_GEN_PARITY_EN
            w_state_nxt = PARITY;
`else
            if (!w_rep_zero) begin
              w_rep_en   = 1'b1;
              w_idx_load = 1'b1;
            end else begin
              w_state_nxt = FINISH;
            end
`endif
          end
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        if (out_ready) begin
          if (!w_rep_zero) begin
            w_rep_en    = 1'b1;
            w_idx_load  = 1'b1;
            w_state_nxt = SHIFT;
          end else begin
            w_state_nxt = FINISH;
          end
        end
      end
`endif
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign load_ready = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FINISH);

`ifdef SEQ_GEN_PARITY_EN
  assign out_valid = (r_state == SHIFT) || (r_state == PARITY);
  assign out_bit   = (r_state == SHIFT)  ? w_data_bit :
                     (r_state == PARITY) ? r_parity   : 1'b0;
`else
  assign out_valid = (r_state == SHIFT);
  assign out_bit   = (r_state == SHIFT) ? w_data_bit : 1'b0;
`endif

  // Zero flag and count of the repeat counter must always agree.
  a_rep_zero_consistent : assert property (@(posedge clk) disable iff (rst)
    w_rep_zero == (w_rep == '0));

endmodule
`default_nettype wire

// File: tb/tb_sequence_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_generator
// Description : Directed, table-driven self-checking bench for sequence_generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_generator;

  localparam int PAT_W = 8;
  localparam int REP_W = 4;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [PAT_W-1:0] load_pattern;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_repeat;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  sequence_generator #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_pattern(load_pattern),
    .load_len    (load_len),
    .load_repeat (load_repeat),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 = ready always high, 1 = two-cycle stall on 2nd beat, 2 = random ready
  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rep;
    int          mode;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   k;
    int   stall;
    logic seen_done;
    logic prev_stall;
    logic prev_bit;
    logic rdy;
    v = vecs[vi];
    @(negedge clk);
    chk("load_ready_idle", load_ready, 1);
    out_ready    = 1'b1;
    load_valid   = 1'b1;
    load_pattern = v.pat;
    load_len     = v.len;
    load_repeat  = v.rep;
    @(negedge clk);
    load_valid   = 1'b0;
    load_pattern = '0;
    k = 0; stall = 0; seen_done = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
    for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 1) chk("first_beat_latency", out_valid, (v.n > 0));
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_bit", out_bit, prev_bit);
      end
      if (done) begin
        seen_done = 1'b1;
        chk("beat_count", k, v.n);
        if (v.mode == 0) chk("done_cycle", cyc, v.n + 1);
        out_ready  = 1'b1;
        prev_stall = 1'b0;
      end else if (out_valid) begin
        case (v.mode)
          1:       rdy = !((k == 1) && (stall < 2));
          2:       rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b1;
        endcase
        if (!rdy) stall++;
        out_ready = rdy;
        if (rdy) begin
          if (k < v.n) chk("beat_bit", out_bit, v.exp[v.n-1-k]);
          k++;
        end
        prev_stall = !rdy;
        prev_bit   = out_bit;
      end else begin
        prev_stall = 1'b0;
        out_ready  = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk("done_seen", seen_done, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("back_idle", load_ready, 1);
  endtask

  initial begin
`ifdef SEQ_GEN_PARITY_EN
    vecs[0] = '{8'h05, 4'd3,  4'd0, 0, 32'b1010,                 4};
    vecs[1] = '{8'h05, 4'd3,  4'd2, 0, 32'b1010_1010_1010,       12};
    vecs[2] = '{8'h0C, 4'd4,  4'd0, 1, 32'b11000,                5};
    vecs[3] = '{8'hFF, 4'd0,  4'd3, 0, 32'b0,                    0};
    vecs[4] = '{8'hA5, 4'd12, 4'd0, 0, 32'b1010_0101_0,          9};
    vecs[5] = '{8'h01, 4'd1,  4'd3, 0, 32'b1111_1111,            8};
    vecs[6] = '{8'hF0, 4'd8,  4'd1, 2, 32'b11110000_0_11110000_0, 18};
    vecs[7] = '{8'h04, 4'd3,  4'd0, 0, 32'b1001,                 4};
    vecs[8] = '{8'h05, 4'd3,  4'd1, 0, 32'b1010_1010,            8};
`else
    vecs[0] = '{8'h05, 4'd3,  4'd0, 0, 32'b101,                  3};
    vecs[1] = '{8'h05, 4'd3,  4'd2, 0, 32'b101_101_101,          9};
    vecs[2] = '{8'h0C, 4'd4,  4'd0, 1, 32'b1100,                 4};
    vecs[3] = '{8'hFF, 4'd0,  4'd3, 0, 32'b0,                    0};
    vecs[4] = '{8'hA5, 4'd12, 4'd0, 0, 32'b1010_0101,            8};
    vecs[5] = '{8'h01, 4'd1,  4'd3, 0, 32'b1111,                 4};
    vecs[6] = '{8'hF0, 4'd8,  4'd1, 2, 32'b11110000_11110000,    16};
    vecs[7] = '{8'h04, 4'd3,  4'd0, 0, 32'b100,                  3};
    vecs[8] = '{8'h05, 4'd3,  4'd1, 0, 32'b101_101,              6};
`endif

    rst = 1'b1; load_valid = 1'b0; load_pattern = '0; load_len = '0;
    load_repeat = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit",   out_bit,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
    chk("rst_load_ready", load_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset mid-burst, with an ignored load attempt during the burst
    @(negedge clk);
    load_valid = 1'b1; load_pattern = 8'hA5; load_len = 4'd8; load_repeat = 4'd0;
    out_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    chk("mid_beat1", out_bit, 1);
    @(negedge clk);
    chk("mid_beat2", out_bit, 0);
    chk("mid_ready_low", load_ready, 0);
    load_valid = 1'b1; load_pattern = 8'hFF; load_len = 4'd2;
    @(negedge clk);
    chk("mid_beat3", out_bit, 1);
    chk("mid_busy", busy, 1);
    rst = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_load_ready", load_ready, 1);
    chk("abort_out_bit", out_bit, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle_valid", out_valid, 0);
    end

    // A fresh burst after the abort still works normally
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
